// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared defaults and FSM state encoding for the RAM-backed FIFO controller.
package ram_fifo_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic [1:0] {
    EMPTY_OUT = 2'd0,
    RD_PEND   = 2'd1,
    OUT_VALID = 2'd2
  } state_e;

endpackage

// File: rtl/ram_fifo_ctrl_ram.sv
// Single-port RAM, one access per cycle, registered read data (1-cycle latency).
// Contents are never cleared; the controller tracks which entries are live.
module single_port_RAM
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[address] <= data_in;
    if (rd_en) data_out <= mem_q[address];
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port RAM with a one-word output register.
// Reads and writes share the RAM port; a pending read always wins the port over a write.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [2:0]        count,
  output logic              full,
  output logic              empty
);

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]        mem_cnt_q, mem_cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              rd_issue;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;

  // Refill the output stage whenever it is empty or is being drained this cycle.
  assign rd_issue = (mem_cnt_q != 3'd0) &&
                    ((state_q == EMPTY_OUT) || ((state_q == OUT_VALID) && out_ready));
  assign in_ready = (mem_cnt_q < DEPTH_C) && !rd_issue;
  assign wr_en    = in_valid && in_ready;
  assign rd_en    = rd_issue;
  assign ram_addr = rd_en ? rd_ptr_q : wr_ptr_q;

  single_port_RAM #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .data_in (in_data),
    .address (ram_addr),
    .data_out(ram_dout)
  );

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_cnt_d = mem_cnt_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({wr_en, rd_en})
      2'b10:   mem_cnt_d = mem_cnt_q + 3'd1;
      2'b01:   mem_cnt_d = mem_cnt_q - 3'd1;
      default: mem_cnt_d = mem_cnt_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    case (state_q)
      EMPTY_OUT: begin
        if (rd_issue) state_d = RD_PEND;
      end
      RD_PEND: begin
        out_data_d = ram_dout;
        state_d    = OUT_VALID;
      end
      OUT_VALID: begin
        if (out_ready) state_d = rd_issue ? RD_PEND : EMPTY_OUT;
      end
      default: state_d = EMPTY_OUT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY_OUT;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= 3'd0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_valid = (state_q == OUT_VALID);
  assign out_data  = out_data_q;
  assign count     = mem_cnt_q + {2'b00, (state_q != EMPTY_OUT)};
  assign full      = (mem_cnt_q == DEPTH_C);
  assign empty     = (count == 3'd0);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: directed scenarios plus randomized traffic against a queue scoreboard.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic [2:0] count;
  logic       full;
  logic       empty;

  int checks = 0;
  int errors = 0;

  bit         mon_en = 1'b0;
  logic [7:0] model_q[$];
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  ram_fifo_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  // Transaction scoreboard: words in flight = accepted minus delivered.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        model_q.delete();
        prev_hold = 1'b0;
      end else begin
        checks++;
        if (count !== 3'(model_q.size())) begin
          errors++;
          $display("FAIL mon_count: got %0d expected %0d", count, model_q.size());
        end
        checks++;
        if (empty !== (model_q.size() == 0)) begin
          errors++;
          $display("FAIL mon_empty: got %b expected %b", empty, model_q.size() == 0);
        end
        checks++;
        if (dut.u_ram.wr_en && dut.u_ram.rd_en) begin
          errors++;
          $display("FAIL mon_port_conflict: wr_en=1 rd_en=1 expected never both");
        end
        if (model_q.size() == 5) begin
          checks++;
          if (in_ready !== 1'b0 || full !== 1'b1) begin
            errors++;
            $display("FAIL mon_full5: in_ready=%b full=%b expected 0/1", in_ready, full);
          end
        end
        if (model_q.size() < 4) begin
          checks++;
          if (full !== 1'b0) begin
            errors++;
            $display("FAIL mon_not_full: full=%b expected 0 with %0d words", full, model_q.size());
          end
        end
        if (prev_hold) begin
          checks++;
          if (out_valid !== 1'b1 || out_data !== prev_data) begin
            errors++;
            $display("FAIL mon_stable: valid=%b data=%h expected 1/%h", out_valid, out_data, prev_data);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (model_q.size() == 0) begin
            errors++;
            $display("FAIL mon_order: got %h expected no output", out_data);
          end else begin
            logic [7:0] exp_d;
            exp_d = model_q.pop_front();
            if (out_data !== exp_d) begin
              errors++;
              $display("FAIL mon_order: got %h expected %h", out_data, exp_d);
            end
          end
        end
        if (in_valid && in_ready) model_q.push_back(in_data);
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, output bit ok);
    in_valid = 1'b1;
    in_data  = d;
    ok = 1'b0;
    for (int t = 0; t < 10 && !ok; t++) begin
      if (in_ready) ok = 1'b1;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++; if (count !== 3'd0)     begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0)      begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_latency();
    in_valid = 1'b1; in_data = 8'hAA;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_e0: out_valid=%b expected 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_e1: out_valid=%b expected 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_e2_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 8'hAA) begin errors++; $display("FAIL lat_e2_data: got %h expected aa", out_data); end
    checks++; if (count !== 3'd1)     begin errors++; $display("FAIL lat_count: got %0d expected 1", count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL lat_drain_empty: got %b expected 1", empty); end
  endtask

  task automatic test_fill();
    int accepted;
    bit ok;
    accepted = 0;
    out_ready = 1'b0;
    for (int w = 1; w <= 6; w++) begin
      push(8'(w), ok);
      if (ok) accepted++;
    end
    checks++; if (accepted != 5)     begin errors++; $display("FAIL fill_accepted: got %0d expected 5", accepted); end
    checks++; if (count !== 3'd5)    begin errors++; $display("FAIL fill_count: got %0d expected 5", count); end
    checks++; if (full !== 1'b1)     begin errors++; $display("FAIL fill_full: got %b expected 1", full); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
  endtask

  task automatic test_drain();
    int got;
    int last_t;
    got = 0; last_t = -1;
    out_ready = 1'b1;
    for (int t = 0; t < 30 && got < 5; t++) begin
      if (out_valid) begin
        checks++;
        if (out_data !== 8'(got + 1)) begin
          errors++; $display("FAIL drain_data: got %h expected %h", out_data, 8'(got + 1));
        end
        if (got > 0) begin
          checks++;
          if (t - last_t != 2) begin
            errors++; $display("FAIL drain_spacing: got %0d cycles expected 2", t - last_t);
          end
        end
        last_t = t;
        got++;
      end
      step();
    end
    checks++; if (got != 5)       begin errors++; $display("FAIL drain_words: got %0d expected 5", got); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
    for (int t = 0; t < 4; t++) begin
      checks++;
      if (dut.u_ram.rd_en !== 1'b0) begin
        errors++; $display("FAIL drain_idle_rd_en: got %b expected 0", dut.u_ram.rd_en);
      end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int got, wr_wraps, rd_wraps;
    logic [1:0] prev_wr, prev_rd;
    bit acc;
    rst = 1'b1; step(); rst = 1'b0;
    got = 0; wr_wraps = 0; rd_wraps = 0;
    prev_wr = dut.wr_ptr_q; prev_rd = dut.rd_ptr_q;
    in_valid = 1'b1; in_data = 8'h10; out_ready = 1'b1;
    for (int t = 0; t < 80 && got < 10; t++) begin
      acc = in_valid && in_ready;
      if (out_valid) begin
        checks++;
        if (out_data !== 8'(8'h10 + got)) begin
          errors++; $display("FAIL wrap_data: got %h expected %h", out_data, 8'(8'h10 + got));
        end
        got++;
      end
      step();
      if (prev_wr == 2'd3 && dut.wr_ptr_q == 2'd0) wr_wraps++;
      if (prev_rd == 2'd3 && dut.rd_ptr_q == 2'd0) rd_wraps++;
      prev_wr = dut.wr_ptr_q; prev_rd = dut.rd_ptr_q;
      if (acc) begin
        if (in_data == 8'h19) in_valid = 1'b0;
        else in_data = in_data + 8'h01;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (got != 10)     begin errors++; $display("FAIL wrap_words: got %0d expected 10", got); end
    checks++; if (wr_wraps != 2) begin errors++; $display("FAIL wrap_wr_ptr: got %0d wraps expected 2", wr_wraps); end
    checks++; if (rd_wraps != 2) begin errors++; $display("FAIL wrap_rd_ptr: got %0d wraps expected 2", rd_wraps); end
  endtask

  task automatic test_backpressure();
    logic [7:0] d0, d1;
    bit ok0, ok1, seen;
    d0 = 8'($urandom); d1 = 8'($urandom);
    out_ready = 1'b0;
    push(d0, ok0);
    push(d1, ok1);
    checks++; if (!(ok0 && ok1)) begin errors++; $display("FAIL bp_push: accepted %b%b expected 11", ok0, ok1); end
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      if (out_valid) seen = 1'b1; else step();
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_timeout: out_valid=0 expected 1"); end
    for (int t = 0; t < 5; t++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== d0) begin
        errors++; $display("FAIL bp_hold: valid=%b data=%h expected 1/%h", out_valid, out_data, d0);
      end
      step();
    end
    out_ready = 1'b1;
    for (int t = 0; t < 20 && !empty; t++) step();
    out_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL bp_drain: empty=%b expected 1", empty); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(8'h30 + 8'(i), ok);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL rstmid_pre_count: got %0d expected 3", count); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (count !== 3'd0)     begin errors++; $display("FAIL rstmid_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    push(8'hC2, ok);
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      if (out_valid) seen = 1'b1; else step();
    end
    checks++;
    if (!seen || out_data !== 8'hC2) begin
      errors++; $display("FAIL rstmid_first: valid=%b data=%h expected 1/c2", seen, out_data);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 600; t++) begin
      rst       = ($urandom_range(0, 149) == 0);
      in_valid  = ($urandom_range(0, 99) < 60);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 99) < 50);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 20 && !empty; t++) step();
    out_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rand_final_empty: got %b expected 1", empty); end
    checks++; if (model_q.size() != 0) begin errors++; $display("FAIL rand_undelivered: %0d words expected 0", model_q.size()); end
  endtask

  initial begin
    mon_en = 1'b1;
    test_reset();
    test_latency();
    test_fill();
    in_valid = 1'b0;
    test_drain();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameters SHALL be DATA_W (default 8, word width), ADDR_W (default 2, RAM address width) and DEPTH (default 4, which is 2**ADDR_W RAM entries).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  the producer presents in_data.
REQ-005 in_data  input  DATA_W  write word.
REQ-006 in_ready  output  1  the block accepts in_data this cycle.
REQ-007 out_valid  output  1  out_data holds the oldest word.
REQ-008 out_data  output  DATA_W  head-of-queue word.
REQ-009 out_ready  input  1  the consumer takes out_data this cycle.
REQ-010 count  output  3  total words held (RAM, in-flight and output register), range 0..5.
REQ-011 full  output  1  high when the RAM word count mem_cnt equals DEPTH.
REQ-012 empty  output  1  high when count equals 0.

Function
REQ-013 The block SHALL be a FIFO upstream of single_port_RAM and SHALL drive its clk, wr_en, rd_en, data_in, address and data_out ports.
REQ-014 RAM read latency SHALL be 1 cycle: rd_en sampled at edge N gives valid data_out after edge N.
REQ-015 Because the RAM is single-port, wr_en and rd_en SHALL never be high in the same cycle.
REQ-016 RAM address SHALL be rd_ptr when rd_en is high, otherwise wr_ptr; RAM data_in SHALL be in_data.
REQ-017 rd_issue SHALL be high when mem_cnt>0 and either state=EMPTY_OUT, or state=OUT_VALID and out_ready is high.
REQ-018 in_ready SHALL equal (mem_cnt<DEPTH) and not rd_issue; this path is combinational from out_ready.
REQ-019 A write SHALL occur when in_valid and in_ready are both high: wr_en=1, wr_ptr increments, mem_cnt increments.
REQ-020 A read SHALL occur when rd_issue is high: rd_en=1, rd_ptr increments, mem_cnt decrements.
REQ-021 Pointers SHALL be ADDR_W bits and wrap from 3 to 0; mem_cnt SHALL be 3 bits, range 0..4.
REQ-022 FSM transitions, EMPTY_OUT: go to RD_PEND when rd_issue, otherwise stay.
REQ-023 FSM transitions, RD_PEND: load out_data from RAM data_out, set out_valid=1, go to OUT_VALID; the RAM port is free for a write in this cycle.
REQ-024 FSM transitions, OUT_VALID: with out_ready=1, go to RD_PEND if rd_issue, else to EMPTY_OUT with out_valid=0; with out_ready=0, hold.
REQ-025 out_valid SHALL be high only in OUT_VALID; out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 count SHALL equal mem_cnt plus 1 when state is not EMPTY_OUT.
REQ-027 Output ordering SHALL be strictly FIFO, including across pointer wrap.
REQ-028 Latency: a word written into an empty block at edge E SHALL show out_valid=1 after edge E+2.
REQ-029 Sustained throughput SHALL be 1 word per 2 cycles.
REQ-030 When the block is full, in_ready=0 and in_valid is ignored; when it is empty, no rd_en is issued.
REQ-031 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-032 When rst=1 at an edge: state=EMPTY_OUT, wr_ptr=rd_ptr=0, mem_cnt=0, out_valid=0, out_data=0; consequently count=0, empty=1, full=0.
REQ-033 rst SHALL override all other activity; a reset asserted mid-operation discards all stored and in-flight words.
REQ-034 RAM contents SHALL NOT be cleared by reset; stale words SHALL never be output, because stored words are tracked only by mem_cnt and the pointers.
REQ-035 in_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-036 A shared package SHALL hold DATA_W, ADDR_W and DEPTH defaults plus the FSM state enum (EMPTY_OUT, RD_PEND, OUT_VALID).
REQ-037 single_port_RAM SHALL be the only sub-module, instantiated once; the FSM, pointers and output register stay in ram_fifo_ctrl.

Verification
REQ-038 The bench SHALL cover these scenarios:
- Latency: reset, then push 8'hAA with out_ready=0 -> out_valid=1 and out_data=AA after 2 edges; count=1.
- Fill: push 01..06 back-to-back with out_ready=0 -> exactly 01..05 accepted, count=5, full=1, in_ready=0, 06 held off.
- Drain: from the fill state, set out_ready=1 -> outputs 01..05 in order, one every 2 cycles, then empty=1 and no rd_en pulse.
- Wrap: stream 8'h10..8'h19 with in_valid=1 and out_ready=1 -> outputs 10..19 in order; wr_ptr and rd_ptr each wrap twice.
- Backpressure: out_valid=1 with out_ready=0 for 5 cycles -> out_data unchanged; wr_en and rd_en never both high at any point.
- Reset: rst=1 for one cycle at count=3 -> count=0 and out_valid=0 next cycle; then push C2 -> first output is C2.
